// File: rtl/gpio_arbiter.sv
// rtl/gpio_arbiter.sv - two-master round-robin arbiter with watchdog for the gpio slave port
module gpio_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_wr,
  input  logic        m0_enable,
  output logic [31:0] m0_data_o,
  output logic        m0_ready,
  output logic        m0_error,

  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_wr,
  input  logic        m1_enable,
  output logic [31:0] m1_data_o,
  output logic        m1_ready,
  output logic        m1_error,

  output logic [31:0] gpio_address,
  output logic [31:0] gpio_data_i,
  output logic [3:0]  gpio_wr,
  output logic        gpio_enable,
  input  logic [31:0] gpio_data_o,
  input  logic        gpio_ready
);

  // Counter wide enough to reach TIMEOUT-1; it is parked at all-ones rather than wrapping.
  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_grant;
  logic          r_last;
  logic [CW-1:0] r_cnt;

  logic          w_access;
  logic          w_timeout;
  logic          w_fire;
  logic          w_error;
  logic [31:0]   w_rdata;
  logic [3:0]    w_sel_wr;

  // Arbitration, access sequencing and watchdog counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_enable || m1_enable) begin
            r_state <= S_ACCESS;
            r_cnt   <= '0;
            // A tie goes to whoever was not served last; otherwise the lone requester wins.
            if (m0_enable && m1_enable) begin
              r_grant <= ~r_last;
            end else begin
              r_grant <= m1_enable;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (gpio_ready || w_timeout) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Enable is low here so the slave can drop its registered ready before the next access.
          r_last  <= r_grant;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_access  = (r_state == S_ACCESS);
  assign w_timeout = (r_cnt == CNT_LAST);
  // Slave ready takes priority over the watchdog when both land in the same cycle.
  assign w_fire    = w_access && (gpio_ready || w_timeout);
  assign w_error   = w_access && !gpio_ready && w_timeout;
  assign w_rdata   = (w_access && gpio_ready) ? gpio_data_o : 32'h0;
  assign w_sel_wr  = r_grant ? m1_wr : m0_wr;

  assign gpio_enable  = w_access;
  assign gpio_address = r_grant ? m1_address : m0_address;
  assign gpio_data_i  = r_grant ? m1_data_i  : m0_data_i;
  assign gpio_wr      = w_access ? w_sel_wr : 4'b0000;

  assign m0_ready  = w_fire  && !r_grant;
  assign m0_error  = w_error && !r_grant;
  assign m0_data_o = r_grant ? 32'h0 : w_rdata;

  assign m1_ready  = w_fire  && r_grant;
  assign m1_error  = w_error && r_grant;
  assign m1_data_o = r_grant ? w_rdata : 32'h0;

endmodule

// File: tb/tb_gpio_arbiter.sv
// tb/tb_gpio_arbiter.sv - scoreboard bench for gpio_arbiter with a registered-ready slave model
module tb_gpio_arbiter;

  localparam logic [31:0] GPIO_I = 32'hA5A5_0F0F;
  localparam logic [31:0] REG2   = 32'h1357_9BDF;
  localparam logic [31:0] REG3   = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [31:0] m0_address = '0, m0_data_i = '0, m0_data_o;
  logic [3:0]  m0_wr = '0;
  logic        m0_enable = 1'b0, m0_ready, m0_error;
  logic [31:0] m1_address = '0, m1_data_i = '0, m1_data_o;
  logic [3:0]  m1_wr = '0;
  logic        m1_enable = 1'b0, m1_ready, m1_error;

  logic [31:0] gpio_address, gpio_data_i;
  logic [3:0]  gpio_wr;
  logic        gpio_enable;
  logic [31:0] gpio_data_o = 32'hDEAD_BEEF;
  logic        gpio_ready = 1'b0;

  logic [31:0] s_oe = '0;
  logic [31:0] exp_oe = '0;

  typedef struct {
    logic        m;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_data_i(m0_data_i), .m0_wr(m0_wr), .m0_enable(m0_enable),
    .m0_data_o(m0_data_o), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_address(m1_address), .m1_data_i(m1_data_i), .m1_wr(m1_wr), .m1_enable(m1_enable),
    .m1_data_o(m1_data_o), .m1_ready(m1_ready), .m1_error(m1_error),
    .gpio_address(gpio_address), .gpio_data_i(gpio_data_i), .gpio_wr(gpio_wr),
    .gpio_enable(gpio_enable), .gpio_data_o(gpio_data_o), .gpio_ready(gpio_ready)
  );

  // Slave: registers at 0x00..0x10, nothing at 0x14 and above; ready is registered off enable.
  always @(posedge clk) begin
    if (gpio_enable && !gpio_ready && gpio_address <= 32'h10 && gpio_address[1:0] == 2'b00) begin
      gpio_ready <= 1'b1;
      if (gpio_wr != 4'b0000) begin
        if (gpio_address[4:2] == 3'd1) begin
          for (int b = 0; b < 4; b++) begin
            if (gpio_wr[b]) s_oe[8*b +: 8] <= gpio_data_i[8*b +: 8];
          end
        end
        gpio_data_o <= 32'h0;
      end else begin
        case (gpio_address[4:2])
          3'd0:    gpio_data_o <= GPIO_I;
          3'd1:    gpio_data_o <= s_oe;
          3'd2:    gpio_data_o <= REG2;
          3'd3:    gpio_data_o <= REG3;
          default: gpio_data_o <= 32'h0;
        endcase
      end
    end else begin
      gpio_ready  <= 1'b0;
      gpio_data_o <= 32'hDEAD_BEEF;
    end
  end

  // Waits for the next ready pulse, compares it against the head of the scoreboard.
  task automatic wait_ready(input int budget, output int lat, output int en_cycles);
    bit   got;
    exp_t e;
    got = 0;
    lat = 0;
    en_cycles = 0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      if (gpio_enable === 1'b1) en_cycles++;
      checks++;
      if (m0_ready === 1'b1 && m1_ready === 1'b1) begin
        errors++;
        $display("FAIL both_ready m0_ready=%b m1_ready=%b required one at most", m0_ready, m1_ready);
      end
      checks++;
      if ((m0_ready !== 1'b1 && (m0_data_o !== 32'h0 || m0_error !== 1'b0)) ||
          (m1_ready !== 1'b1 && (m1_data_o !== 32'h0 || m1_error !== 1'b0))) begin
        errors++;
        $display("FAIL silent_master m0_data_o=%h m0_error=%b m1_data_o=%h m1_error=%b required zero when not ready",
                 m0_data_o, m0_error, m1_data_o, m1_error);
      end
      if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
        got = 1;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready m0_ready=%b m1_ready=%b required none", m0_ready, m1_ready);
        end else begin
          e = q.pop_front();
          if (m1_ready !== e.m) begin
            errors++;
            $display("FAIL grant_order ready_master=%0d required %0d", m1_ready, e.m);
          end
          checks++;
          if ((e.m ? m1_data_o : m0_data_o) !== e.data) begin
            errors++;
            $display("FAIL read_data got %h required %h", e.m ? m1_data_o : m0_data_o, e.data);
          end
          checks++;
          if ((e.m ? m1_error : m0_error) !== e.err) begin
            errors++;
            $display("FAIL error_flag got %b required %b", e.m ? m1_error : m0_error, e.err);
          end
        end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_wait no ready within %0d cycles required a pulse", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m0_enable = 1'b1;
    m1_enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (gpio_enable !== 1'b0 || gpio_wr !== 4'b0) begin
      errors++;
      $display("FAIL reset_gpio enable=%b wr=%b required 0/0", gpio_enable, gpio_wr);
    end
    checks++;
    if ({m0_ready, m0_error, m1_ready, m1_error} !== 4'b0 || m0_data_o !== 32'h0 || m1_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_masters rdy/err=%b%b%b%b data=%h/%h required all zero",
               m0_ready, m0_error, m1_ready, m1_error, m0_data_o, m1_data_o);
    end
    m0_enable = 1'b0;
    m1_enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gpio_enable !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset enable=%b required 0", gpio_enable);
    end
  endtask

  task automatic test_round_robin();
    int lat, en;
    m0_address = 32'h00; m0_wr = 4'b0;
    m1_address = 32'h08; m1_wr = 4'b0;
    for (int i = 0; i < 8; i++) q.push_back('{m: i[0], data: (i[0] ? REG2 : GPIO_I), err: 1'b0});
    m0_enable = 1'b1;
    m1_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_ready(32, lat, en);
      checks++;
      if (lat !== ((i == 0) ? 2 : 4)) begin
        errors++;
        $display("FAIL rr_spacing pulse %0d after %0d cycles required %0d", i, lat, (i == 0) ? 2 : 4);
      end
    end
    m0_enable = 1'b0;
    m1_enable = 1'b0;
  endtask

  task automatic test_m0_read();
    int lat, en;
    repeat (2) @(negedge clk);
    m0_address = 32'h00; m0_wr = 4'b0; m0_data_i = 32'h1111_2222;
    q.push_back('{m: 1'b0, data: GPIO_I, err: 1'b0});
    m0_enable = 1'b1;
    wait_ready(8, lat, en);
    m0_enable = 1'b0;
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL m0_read_latency got %0d required 2", lat);
    end
    // Enable spans both ACCESS cycles: the request cycle's successor and the ready cycle.
    checks++;
    if (en !== 2) begin
      errors++;
      $display("FAIL m0_read_enable_cycles got %0d required 2", en);
    end
    @(negedge clk);
    checks++;
    if (gpio_enable !== 1'b0) begin
      errors++;
      $display("FAIL m0_read_done_enable got %b required 0", gpio_enable);
    end
  endtask

  task automatic test_m1_write();
    int lat, en;
    repeat (2) @(negedge clk);
    m1_address = 32'h04; m1_wr = 4'b0010; m1_data_i = 32'hAABB_FF00;
    for (int b = 0; b < 4; b++) if (m1_wr[b]) exp_oe[8*b +: 8] = m1_data_i[8*b +: 8];
    q.push_back('{m: 1'b1, data: 32'h0, err: 1'b0});
    m1_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (gpio_address !== 32'h04 || gpio_wr !== 4'b0010 || gpio_data_i !== 32'hAABB_FF00) begin
      errors++;
      $display("FAIL m1_forward addr=%h wr=%b data=%h required 00000004/0010/aabbff00",
               gpio_address, gpio_wr, gpio_data_i);
    end
    wait_ready(8, lat, en);
    m1_enable = 1'b0;
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL m1_write_latency got %0d required 1", lat);
    end
    checks++;
    if (s_oe !== exp_oe) begin
      errors++;
      $display("FAIL m1_write_oe got %h required %h", s_oe, exp_oe);
    end
  endtask

  task automatic test_timeout();
    int lat, en;
    repeat (2) @(negedge clk);
    m0_address = 32'h14; m0_wr = 4'b0;
    m1_address = 32'h0C; m1_wr = 4'b0;
    q.push_back('{m: 1'b0, data: 32'h0, err: 1'b1});
    q.push_back('{m: 1'b1, data: REG3, err: 1'b0});
    m0_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (gpio_enable !== 1'b1 || gpio_address !== 32'h14) begin
      errors++;
      $display("FAIL timeout_grant enable=%b addr=%h required 1/00000014", gpio_enable, gpio_address);
    end
    m1_enable = 1'b1;
    wait_ready(40, lat, en);
    m0_enable = 1'b0;
    checks++;
    if (lat + 1 !== 16 || en + 1 !== 16) begin
      errors++;
      $display("FAIL timeout_cycles error at T+%0d with enable %0d cycles required 16/16", lat + 1, en + 1);
    end
    wait_ready(16, lat, en);
    m1_enable = 1'b0;
    checks++;
    if (lat !== 4 || en !== 2) begin
      errors++;
      $display("FAIL timeout_followup latency=%0d enable=%0d required 4/2", lat, en);
    end
  endtask

  task automatic test_back_to_back();
    int lat, en;
    repeat (2) @(negedge clk);
    m0_address = 32'h04; m0_wr = 4'b0;
    q.push_back('{m: 1'b0, data: exp_oe, err: 1'b0});
    m0_enable = 1'b1;
    wait_ready(8, lat, en);
    m0_enable = 1'b0;
    @(negedge clk);
    checks++;
    if (gpio_enable !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_enable got %b required 0", gpio_enable);
    end
    @(negedge clk);
    m0_address = 32'h08;
    q.push_back('{m: 1'b0, data: REG2, err: 1'b0});
    m0_enable = 1'b1;
    wait_ready(8, lat, en);
    m0_enable = 1'b0;
    checks++;
    if (lat + 2 !== 4) begin
      errors++;
      $display("FAIL b2b_spacing got %0d required 4", lat + 2);
    end
  endtask

  task automatic test_reset_mid();
    int lat, en;
    int bad;
    repeat (2) @(negedge clk);
    m0_address = 32'h10; m0_wr = 4'b0;
    m0_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (gpio_enable !== 1'b1) begin
      errors++;
      $display("FAIL mid_access enable=%b required 1", gpio_enable);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (gpio_enable !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset enable=%b m0_ready=%b m1_ready=%b required 0/0/0", gpio_enable, m0_ready, m1_ready);
    end
    m0_enable = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || gpio_enable !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_hold activity in %0d cycles required 0", bad);
    end
    rst = 1'b1;
    @(negedge clk);
    m0_address = 32'h00; m1_address = 32'h08;
    q.push_back('{m: 1'b0, data: GPIO_I, err: 1'b0});
    q.push_back('{m: 1'b1, data: REG2, err: 1'b0});
    m0_enable = 1'b1;
    m1_enable = 1'b1;
    wait_ready(8, lat, en);
    m0_enable = 1'b0;
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL post_reset_first latency=%0d required 2", lat);
    end
    wait_ready(8, lat, en);
    m1_enable = 1'b0;
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL post_reset_second latency=%0d required 4", lat);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_m0_read();
    test_m1_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain %0d entries left required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
